reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 3, entry tag width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 dispatch_valid  input  1  allocate one entry this cycle.
REQ-006 dispatch_rd  input  5  destination register of the allocated instruction.
REQ-007 dispatch_pc  input  32  PC of the allocated instruction.
REQ-008 dispatch_ready  output  1  an entry is free.
REQ-009 dispatch_tag  output  TAG_W  tag the entry receives (tail pointer).
REQ-010 cdb_valid  input  1  result broadcast.
REQ-011 cdb_tag  input  TAG_W  entry completed by the broadcast.
REQ-012 cdb_data  input  32  result value.
REQ-013 commit  input  1  registered retire pulse from commit control.
REQ-014 commit_ready  output  1  the effective head is complete.
REQ-015 cir_q_empty  output  1  no effective entries remain.
REQ-016 retire_valid, retire_rd[5], retire_data[32], retire_pc[32]  outputs  head entry being retired this cycle.
REQ-017 commit_err  output  1  sticky: commit arrived with buffer empty.

Function
REQ-018 Circular buffer, head/tail pointers TAG_W bits wrapping DEPTH-1 to 0, plus a count of TAG_W+1 bits.
REQ-019 dispatch_ready SHALL be 1 iff count < DEPTH; dispatch_valid with dispatch_ready low SHALL be ignored.
REQ-020 Accepted dispatch writes rd, pc, done=0 at tail; tail advances by 1 next edge.
REQ-021 cdb_valid SHALL set done and store cdb_data at cdb_tag next edge; a broadcast to an unallocated tag SHALL be ignored.
REQ-022 Effective head = head+1 when commit is high, otherwise head; effective count = count-commit (saturating at 0).
REQ-023 commit_ready = (effective count != 0) AND done[effective head], combinational from registered state only; a same-cycle broadcast becomes visible next cycle.
REQ-024 cir_q_empty = (effective count == 0).
REQ-025 REQ-022..024 SHALL make the one-cycle commit-pulse delay safe: back-to-back commits retire consecutive completed entries, never an incomplete one.
REQ-026 commit high with count != 0: retire_valid=1 and retire_* show head combinationally; head advances and done[head] clears next edge.
REQ-027 commit high with count == 0: no state change, retire_valid=0, commit_err set.
REQ-028 Simultaneous accepted dispatch and commit: count unchanged, both pointers advance.
REQ-029 Broadcast and commit to the same tag in one cycle: commit wins; the entry is freed.

Reset
REQ-030 On rst low, immediately: head=tail=count=0, all done=0, commit_err=0; outputs dispatch_ready=1, dispatch_tag=0, commit_ready=0, cir_q_empty=1, retire_valid=0.
REQ-031 Entry payload (rd, pc, data) SHALL NOT require reset.
REQ-032 Reset asserted mid-operation discards all entries; no retire occurs in the reset cycle.

Configuration
REQ-033 Macro ROB_FLUSH_EN, when defined, adds input flush (1 bit): on a flush edge head=tail=count=0, all done cleared, commit ignored that cycle; flush has priority over dispatch, broadcast and commit.
REQ-034 Without ROB_FLUSH_EN the flush port and logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-035 Shared package rob_pkg SHALL hold DEPTH/TAG_W defaults and the rob_entry_t typedef (rd, pc, data, done).
REQ-036 No sub-module; single module with the entry array and pointer logic.

Verification
REQ-037 Reset, then dispatch 3 entries -> tags 0,1,2; count=3; cir_q_empty=0; commit_ready=0.
REQ-038 Complete tag 0 (data 0x11) -> next cycle commit_ready=1; commit pulse -> retire_data=0x11, rd/pc match dispatch.
REQ-039 Complete tags 0,1 only, commit held high 3 cycles -> exactly 2 retires, commit_ready=0 in the second commit cycle (tag 2 not done), no retire of tag 2.
REQ-040 Fill 8 entries -> dispatch_ready=0, 9th dispatch ignored; commit plus dispatch same cycle -> count stays 8, tail wraps to 0.
REQ-041 commit with empty buffer -> commit_err=1, pointers unchanged.
REQ-042 With ROB_FLUSH_EN: 5 entries, flush -> cir_q_empty=1, dispatch_tag=0 next cycle; rst low mid-stream -> same state immediately, asynchronously.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions.
// Default geometry and the per-entry record.
package rob_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] data;
    logic        done;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order dispatch/retire, out-of-order completion.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_rd,
  input  logic [31:0]      dispatch_pc,
  output logic             dispatch_ready,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             commit,
  output logic             commit_ready,
  output logic             cir_q_empty,
  output logic             retire_valid,
  output logic [4:0]       retire_rd,
  output logic [31:0]      retire_data,
  output logic [31:0]      retire_pc,
  output logic             commit_err
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  rob_entry_t       rob_q [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             err_q;

  logic             accept;
  logic             nonempty;
  logic             retire;
  logic             cdb_hit;
  logic [TAG_W-1:0] cdb_off;
  logic [TAG_W-1:0] eff_head;
  logic [TAG_W:0]   eff_count;
  logic             flush_now;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // handshake, completion hit and look-ahead head for the delayed commit pulse
  always_comb begin
    nonempty  = (count != '0);
    accept    = dispatch_valid & (count < FULL_CNT);
    retire    = commit & nonempty & rob_q[head].done & ~flush_now;
    cdb_off   = cdb_tag - head;
    cdb_hit   = cdb_valid & ({1'b0, cdb_off} < count);
    eff_head  = commit ? head + 1'b1 : head;
    eff_count = (commit & nonempty) ? count - 1'b1 : count;
  end

  assign dispatch_ready = (count < FULL_CNT);
  assign dispatch_tag   = tail;
  assign commit_ready   = (eff_count != '0) & rob_q[eff_head].done;
  assign cir_q_empty    = (eff_count == '0);
  assign retire_valid   = retire;
  assign retire_rd      = rob_q[head].rd;
  assign retire_data    = rob_q[head].data;
  assign retire_pc      = rob_q[head].pc;
  assign commit_err     = err_q;

  // pointers, occupancy, entry array and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        rob_q[i].done <= 1'b0;
`ifdef ROB_FLUSH_EN
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        rob_q[i].done <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rob_q[tail].rd   <= dispatch_rd;
        rob_q[tail].pc   <= dispatch_pc;
        rob_q[tail].done <= 1'b0;
        tail             <= tail + 1'b1;
      end
      if (cdb_hit) begin
        rob_q[cdb_tag].data <= cdb_data;
        rob_q[cdb_tag].done <= 1'b1;
      end
      // retiring last so a same-tag broadcast cannot revive a freed entry
      if (retire) begin
        rob_q[head].done <= 1'b0;
        head             <= head + 1'b1;
      end
      unique case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (commit && !nonempty)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
// Inputs change on the falling edge; checks run 1ns later.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dispatch_valid;
  logic [4:0]  dispatch_rd;
  logic [31:0] dispatch_pc;
  logic        dispatch_ready;
  logic [2:0]  dispatch_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit;
  logic        commit_ready;
  logic        cir_q_empty;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic [31:0] retire_pc;
  logic        commit_err;

  int n_assert = 0;
  int n_fail   = 0;

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef ROB_FLUSH_EN
    .flush          (flush),
`endif
    .dispatch_valid (dispatch_valid),
    .dispatch_rd    (dispatch_rd),
    .dispatch_pc    (dispatch_pc),
    .dispatch_ready (dispatch_ready),
    .dispatch_tag   (dispatch_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .commit         (commit),
    .commit_ready   (commit_ready),
    .cir_q_empty    (cir_q_empty),
    .retire_valid   (retire_valid),
    .retire_rd      (retire_rd),
    .retire_data    (retire_data),
    .retire_pc      (retire_pc),
    .commit_err     (commit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    dispatch_valid = 1'b0; dispatch_rd = '0; dispatch_pc = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; commit = 1'b0;
    #1;
    chk("rst_ready", 32'(dispatch_ready), 1);
    chk("rst_tag", 32'(dispatch_tag), 0);
    chk("rst_cready", 32'(commit_ready), 0);
    chk("rst_empty", 32'(cir_q_empty), 1);
    chk("rst_rvalid", 32'(retire_valid), 0);
    chk("rst_err", 32'(commit_err), 0);
    @(negedge clk);
    rst = 1'b1;

    // three dispatches get tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      dispatch_valid = 1'b1;
      dispatch_rd = 5'(i + 1);
      dispatch_pc = 32'h100 + 32'(4 * i);
      #1 chk("a_tag", 32'(dispatch_tag), i);
      @(negedge clk);
    end
    dispatch_valid = 1'b0;
    #1;
    chk("a_count", 32'(dut.count), 3);
    chk("a_empty", 32'(cir_q_empty), 0);
    chk("a_cready", 32'(commit_ready), 0);

    // completion of tag 0 becomes visible one cycle later
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h11;
    #1 chk("b_cready_same", 32'(commit_ready), 0);
    @(negedge clk);
    cdb_valid = 1'b0;
    #1 chk("b_cready", 32'(commit_ready), 1);
    @(negedge clk);
    commit = 1'b1;
    #1;
    chk("b_rvalid", 32'(retire_valid), 1);
    chk("b_rdata", retire_data, 32'h11);
    chk("b_rrd", 32'(retire_rd), 1);
    chk("b_rpc", retire_pc, 32'h100);
    chk("b_cready_next", 32'(commit_ready), 0);
    @(negedge clk);
    commit = 1'b0;
    #1 chk("b_count", 32'(dut.count), 2);

    // asynchronous reset mid-stream, with a commit pending
    commit = 1'b1;
    rst = 1'b0;
    #1;
    chk("r_empty", 32'(cir_q_empty), 1);
    chk("r_tag", 32'(dispatch_tag), 0);
    chk("r_count", 32'(dut.count), 0);
    chk("r_rvalid", 32'(retire_valid), 0);
    @(negedge clk);
    rst = 1'b1; commit = 1'b0;

    // tags 0,1 complete, 2 not; commit held three cycles
    for (int i = 0; i < 3; i++) begin
      dispatch_valid = 1'b1;
      dispatch_rd = 5'(i + 5);
      dispatch_pc = 32'h200 + 32'(4 * i);
      @(negedge clk);
    end
    dispatch_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'hA0;
    @(negedge clk);
    cdb_tag = 3'd1; cdb_data = 32'hA1;
    @(negedge clk);
    cdb_valid = 1'b0;
    #1 chk("c_cready0", 32'(commit_ready), 1);
    @(negedge clk);
    commit = 1'b1;
    #1;
    chk("c1_rvalid", 32'(retire_valid), 1);
    chk("c1_rdata", retire_data, 32'hA0);
    chk("c1_rrd", 32'(retire_rd), 5);
    chk("c1_cready", 32'(commit_ready), 1);
    @(negedge clk);
    #1;
    chk("c2_rvalid", 32'(retire_valid), 1);
    chk("c2_rdata", retire_data, 32'hA1);
    chk("c2_cready", 32'(commit_ready), 0);
    @(negedge clk);
    #1;
    chk("c3_rvalid", 32'(retire_valid), 0);
    chk("c3_cready", 32'(commit_ready), 0);
    chk("c3_empty", 32'(cir_q_empty), 1);
    @(negedge clk);
    commit = 1'b0;
    #1;
    chk("c_count", 32'(dut.count), 1);
    chk("c_head", 32'(dut.head), 2);
    chk("c_err", 32'(commit_err), 0);

    // broadcast to an already-retired slot is ignored
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'hFF;
    @(negedge clk);
    cdb_valid = 1'b0;
    #1 chk("u_done0", 32'(dut.rob_q[0].done), 0);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'hA2;
    @(negedge clk);
    cdb_valid = 1'b0; commit = 1'b1;
    #1;
    chk("d_rvalid", 32'(retire_valid), 1);
    chk("d_rdata", retire_data, 32'hA2);
    chk("d_rrd", 32'(retire_rd), 7);
    chk("d_rpc", retire_pc, 32'h208);
    @(negedge clk);
    commit = 1'b0;
    #1 chk("d_empty", 32'(cir_q_empty), 1);

    // commit on an empty buffer
    commit = 1'b1;
    #1 chk("e_rvalid", 32'(retire_valid), 0);
    @(negedge clk);
    commit = 1'b0;
    #1;
    chk("e_err", 32'(commit_err), 1);
    chk("e_head", 32'(dut.head), 3);
    chk("e_tail", 32'(dut.tail), 3);
    chk("e_count", 32'(dut.count), 0);
    @(negedge clk);
    #1 chk("e_sticky", 32'(commit_err), 1);

    // fill, simultaneous dispatch+commit with tail wrap, overflow
    rst = 1'b0;
    #1 chk("f_err_clr", 32'(commit_err), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dispatch_valid = 1'b1;
      dispatch_rd = 5'(i);
      dispatch_pc = 32'h300 + 32'(4 * i);
      @(negedge clk);
    end
    dispatch_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'hB0;
    @(negedge clk);
    cdb_valid = 1'b0;
    commit = 1'b1;
    dispatch_valid = 1'b1; dispatch_rd = 5'd20; dispatch_pc = 32'h400;
    #1;
    chk("f_tag7", 32'(dispatch_tag), 7);
    chk("f_rvalid", 32'(retire_valid), 1);
    chk("f_rdata", retire_data, 32'hB0);
    @(negedge clk);
    commit = 1'b0;
    dispatch_rd = 5'd21; dispatch_pc = 32'h404;
    #1;
    chk("f_count7", 32'(dut.count), 7);
    chk("f_tail_wrap", 32'(dispatch_tag), 0);
    chk("f_head", 32'(dut.head), 1);
    chk("f_ready7", 32'(dispatch_ready), 1);
    @(negedge clk);
    dispatch_rd = 5'd22; dispatch_pc = 32'h408;
    #1;
    chk("f_full_ready", 32'(dispatch_ready), 0);
    chk("f_count8", 32'(dut.count), 8);
    @(negedge clk);
    dispatch_valid = 1'b0;
    #1;
    chk("f_ovf_count", 32'(dut.count), 8);
    chk("f_ovf_tail", 32'(dispatch_tag), 1);

    // broadcast and commit to the same tag: entry is freed
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'hC1;
    @(negedge clk);
    cdb_data = 32'hEE; commit = 1'b1;
    #1;
    chk("g_rdata", retire_data, 32'hC1);
    chk("g_rrd", 32'(retire_rd), 1);
    chk("g_rpc", retire_pc, 32'h304);
    @(negedge clk);
    cdb_valid = 1'b0; commit = 1'b0;
    #1;
    chk("g_done1", 32'(dut.rob_q[1].done), 0);
    chk("g_head", 32'(dut.head), 2);
    chk("g_count", 32'(dut.count), 7);

`ifdef ROB_FLUSH_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dispatch_valid = 1'b1;
      dispatch_rd = 5'(i);
      dispatch_pc = 32'h500 + 32'(4 * i);
      @(negedge clk);
    end
    flush = 1'b1; commit = 1'b1;
    @(negedge clk);
    flush = 1'b0; commit = 1'b0; dispatch_valid = 1'b0;
    #1;
    chk("h_empty", 32'(cir_q_empty), 1);
    chk("h_tag", 32'(dispatch_tag), 0);
    chk("h_count", 32'(dut.count), 0);
    chk("h_err", 32'(commit_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
